// File: rtl/riscv_mem_responder.sv
// Word-addressed memory responder for a RISC-V core: one request in flight, programmable wait states.
// Optional `RISCV_MEM_RESP_MISALIGN_CHECK_EN rejects requests whose address is not word aligned.
module riscv_mem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state_q, state_d;
    logic [3:0]  wait_cnt;
    logic        lat_we;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;
    logic [3:0]  lat_be;

    logic        accept;
    logic        enter_resp;
    logic        cur_we;
    logic [31:0] cur_addr;
    logic [31:0] cur_wdata;
    logic [3:0]  cur_be;
    logic [AW-1:0] cur_idx;
    logic        cur_err;

    logic [31:0] mem [DEPTH_WORDS];

    assign req_ready = (state_q == IDLE);
    assign accept    = req_valid && req_ready;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (accept) state_d = (WAIT_CYCLES == 0) ? RESP : WAIT;
            WAIT: if (wait_cnt == 4'(WAIT_CYCLES - 1)) state_d = RESP;
            RESP: if (rsp_valid && rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // With zero wait states the commit happens on the accept edge itself,
    // so the live request is used instead of the latched copy.
    always_comb begin
        if (state_q == IDLE) begin
            cur_we    = req_we;
            cur_addr  = req_addr;
            cur_wdata = req_wdata;
            cur_be    = req_be;
        end else begin
            cur_we    = lat_we;
            cur_addr  = lat_addr;
            cur_wdata = lat_wdata;
            cur_be    = lat_be;
        end
    end

    assign cur_idx    = cur_addr[AW+1:2];
    assign enter_resp = (state_q != RESP) && (state_d == RESP);

`ifdef RISCV_MEM_RESP_MISALIGN_CHECK_EN
    assign cur_err = (cur_addr[31:AW+2] != '0) || (cur_addr[1:0] != 2'b00);
`else
    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^cur_addr[1:0];
    assign cur_err = (cur_addr[31:AW+2] != '0);
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            wait_cnt  <= '0;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_be    <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                wait_cnt  <= '0;
                lat_we    <= req_we;
                lat_addr  <= req_addr;
                lat_wdata <= req_wdata;
                lat_be    <= req_be;
            end else if (state_q == WAIT) begin
                wait_cnt <= wait_cnt + 4'd1;
            end
        end
    end

    // Data/err are loaded on RESP entry; valid follows one edge later.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            if (rsp_valid && rsp_ready) begin
                rsp_valid <= 1'b0;
                rsp_rdata <= '0;
                rsp_err   <= 1'b0;
            end else if (enter_resp) begin
                rsp_err   <= cur_err;
                rsp_rdata <= (!cur_we && !cur_err) ? mem[cur_idx] : '0;
            end else if (state_q == RESP) begin
                rsp_valid <= 1'b1;
            end
        end
    end

    // Memory is deliberately outside the reset domain.
    always_ff @(posedge clk) begin
        if (enter_resp && cur_we && !cur_err) begin
            for (int unsigned k = 0; k < 4; k++) begin
                if (cur_be[k]) mem[cur_idx][8*k +: 8] <= cur_wdata[8*k +: 8];
            end
        end
    end

endmodule

// File: tb/tb_riscv_mem_responder.sv
// Randomized self-checking bench for riscv_mem_responder against a word-array reference model.
module tb_riscv_mem_responder;

    localparam int unsigned DEPTH = 1024;
    localparam int unsigned WAITC = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int unsigned total = 0;
    int unsigned bad   = 0;

    logic [31:0] ref_mem [DEPTH];

    riscv_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WAITC)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_be    (req_be),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic ref_err(input logic [31:0] a);
        logic e;
        e = (a >= 32'(4 * DEPTH));
`ifdef RISCV_MEM_RESP_MISALIGN_CHECK_EN
        e = e || (a[1:0] != 2'b00);
`endif
        return e;
    endfunction

    // One full transaction: request, latency check, `hold` cycles of backpressure, handshake.
    task automatic xact(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [3:0] be, input int unsigned hold);
        logic        exp_e;
        logic [31:0] exp_d;
        int unsigned idx;
        int unsigned cyc;
        exp_e = ref_err(addr);
        idx   = int'(addr / 4) % DEPTH;
        exp_d = (we || exp_e) ? 32'h0 : ref_mem[idx];

        @(negedge clk);
        check("req_ready_idle", 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wd;
        req_be    = be;
        @(posedge clk);
        #1 req_valid = 1'b0;
        cyc = 0;
        while (!rsp_valid && cyc < 40) begin
            @(posedge clk);
            #1 cyc++;
        end
        check("latency", 32'(cyc), 32'(1 + WAITC));
        check("rsp_err", 32'(rsp_err), 32'(exp_e));
        check("rsp_rdata", rsp_rdata, exp_d);
        repeat (hold) begin
            @(posedge clk);
            #1;
            check("hold_valid", 32'(rsp_valid), 32'd1);
            check("hold_rdata", rsp_rdata, exp_d);
            check("hold_req_ready", 32'(req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        check("post_valid", 32'(rsp_valid), 32'd0);
        check("post_req_ready", 32'(req_ready), 32'd1);
        check("post_rdata", rsp_rdata, 32'h0);

        if (we && !exp_e) begin
            for (int k = 0; k < 4; k++)
                if (be[k]) ref_mem[idx][8*k +: 8] = wd[8*k +: 8];
        end
    endtask

    initial begin
        logic [31:0] a;
        reset     = 1'b1;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        req_be    = '0;
        rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk) reset = 1'b0;
        check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset_rsp_rdata", rsp_rdata, 32'h0);
        check("reset_rsp_err", 32'(rsp_err), 32'd0);
        check("reset_req_ready", 32'(req_ready), 32'd1);

        for (int w = 0; w < 64; w++) xact(1'b1, 32'(w * 4), $urandom, 4'hF, 0);
        for (int w = 1020; w < 1024; w++) xact(1'b1, 32'(w * 4), $urandom, 4'hF, 0);

        xact(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0);
        xact(1'b0, 32'h10, 32'h0, 4'h0, 0);
        xact(1'b1, 32'h10, 32'h000000AA, 4'h1, 0);
        xact(1'b0, 32'h10, 32'h0, 4'hF, 1);
        check("byte_merge_model", ref_mem[4], 32'hDEADBEAA);
        xact(1'b0, 32'h20, 32'h0, 4'h0, 5);
        xact(1'b0, 32'h1000, 32'h0, 4'hF, 0);
        xact(1'b1, 32'h1000, 32'hCAFEF00D, 4'hF, 0);
        xact(1'b0, 32'h0, 32'h0, 4'hF, 0);
        xact(1'b1, 32'h24, 32'h55555555, 4'h0, 2);
        xact(1'b0, 32'h24, 32'h0, 4'h0, 0);
        xact(1'b0, 32'h12, 32'h0, 4'hF, 0);
        xact(1'b0, 32'hFFC, 32'h0, 4'hF, 0);

        // Reset while a write is waiting must drop it without touching memory.
        xact(1'b1, 32'h40, 32'h11111111, 4'hF, 0);
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 32'h40;
        req_wdata = 32'h22222222;
        req_be    = 4'hF;
        @(posedge clk);
        #1 req_valid = 1'b0;
        reset = 1'b1;
        #1 check("rst_wait_valid", 32'(rsp_valid), 32'd0);
        @(posedge clk);
        @(negedge clk) reset = 1'b0;
        check("rst_wait_req_ready", 32'(req_ready), 32'd1);
        repeat (4) @(posedge clk);
        #1 check("rst_wait_no_rsp", 32'(rsp_valid), 32'd0);
        xact(1'b0, 32'h40, 32'h0, 4'h0, 0);

        for (int n = 0; n < 250; n++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4, 5, 6: a = 32'($urandom_range(0, 255));
                7, 8:                a = 32'h0FF0 + 32'($urandom_range(0, 31));
                default:             a = $urandom | 32'h0000_1000;
            endcase
            xact(1'($urandom), a, $urandom, 4'($urandom), $urandom_range(0, 3));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: got=stalled expected=finish");
        $fatal(1);
    end

endmodule
